// File: rtl/sideband_commit_buffer.sv
// Sideband descriptor staging register plus commit-gated first-word-fall-through FIFO.
// A descriptor enters the FIFO only when its frame is committed; drops and aborts are counted.
module sideband_commit_buffer #(
    parameter int W_EL         = 20,
    parameter int ADDR_WIDTH   = 9,
    parameter int AFULL_MARGIN = 4,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sb_start,
    input  logic                  sb_wen,
    input  logic [W_EL-1:0]       sb_wdata,
    input  logic                  sb_commit,
    input  logic                  sb_drop,
    output logic                  rd_valid,
    output logic [W_EL-1:0]       rd_data,
    input  logic                  rd_ready,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  almost_full,
    output logic                  sb_overflow,
    output logic                  sb_proto_err,
    output logic [CNT_W-1:0]      drop_cnt,
    output logic [CNT_W-1:0]      ovf_cnt
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AFULL_C = (ADDR_WIDTH + 1)'(DEPTH - AFULL_MARGIN);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
    localparam logic [CNT_W-1:0]      STAT_ONE = CNT_W'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OPEN = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [W_EL-1:0]       stage_q, stage_d;
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  afull_q, afull_d;
    logic                  ovf_q, ovf_d;
    logic                  perr_q, perr_d;
    logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]      ovf_cnt_q, ovf_cnt_d;

    logic                  push_req;
    logic                  push_ok;
    logic                  pop;
    logic                  drop_inc;
    logic [W_EL-1:0]       push_data;

    logic [W_EL-1:0]       mem [DEPTH];

    assign pop = (count_q != '0) && rd_ready;

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        push_req  = 1'b0;
        push_data = stage_q;
        drop_inc  = 1'b0;
        perr_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sb_start) begin
                    state_d = S_OPEN;
                    stage_d = '0;
                end else if (sb_wen || sb_commit || sb_drop) begin
                    perr_d = 1'b1;
                end
            end
            S_OPEN: begin
                // Same-cycle priority: drop, then start (abort), then commit, then write.
                if (sb_drop) begin
                    state_d  = S_IDLE;
                    drop_inc = 1'b1;
                end else if (sb_start) begin
                    stage_d  = '0;
                    drop_inc = 1'b1;
                end else if (sb_commit) begin
                    state_d   = S_IDLE;
                    push_req  = 1'b1;
                    push_data = sb_wen ? sb_wdata : stage_q;
                end else if (sb_wen) begin
                    stage_d = sb_wdata;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push_ok = push_req && ((count_q != DEPTH_C) || pop);
        ovf_d   = push_req && !push_ok;

        wptr_d  = push_ok ? wptr_q + PTR_ONE : wptr_q;
        rptr_d  = pop ? rptr_q + PTR_ONE : rptr_q;

        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_ok && pop) begin
            count_d = count_q - CNT_ONE;
        end
        full_d  = (count_d == DEPTH_C);
        afull_d = (count_d >= AFULL_C);

        drop_cnt_d = (drop_inc && drop_cnt_q != '1) ? drop_cnt_q + STAT_ONE : drop_cnt_q;
        ovf_cnt_d  = (ovf_d && ovf_cnt_q != '1) ? ovf_cnt_q + STAT_ONE : ovf_cnt_q;
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            stage_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            ovf_q      <= 1'b0;
            perr_q     <= 1'b0;
            drop_cnt_q <= '0;
            ovf_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            afull_q    <= afull_d;
            ovf_q      <= ovf_d;
            perr_q     <= perr_d;
            drop_cnt_q <= drop_cnt_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    // NOTE: the storage array has no reset; count gates rd_valid, so stale words are never observed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr_q] <= push_data;
        end
    end

    assign rd_valid     = (count_q != '0);
    assign rd_data      = mem[rptr_q];
    assign count        = count_q;
    assign full         = full_q;
    assign almost_full  = afull_q;
    assign sb_overflow  = ovf_q;
    assign sb_proto_err = perr_q;
    assign drop_cnt     = drop_cnt_q;
    assign ovf_cnt      = ovf_cnt_q;

endmodule

// File: tb/tb_sideband_commit_buffer.sv
// Testbench for sideband_commit_buffer: directed table, multi-cycle corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_sideband_commit_buffer;

    localparam int W_EL  = 20;
    localparam int AW    = 9;
    localparam int DEPTH = 2 ** AW;
    localparam int CNT_W = 16;
    localparam int CMAX  = 2 ** CNT_W - 1;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            sb_start = 1'b0;
    logic            sb_wen = 1'b0;
    logic [W_EL-1:0] sb_wdata = '0;
    logic            sb_commit = 1'b0;
    logic            sb_drop = 1'b0;
    logic            rd_ready = 1'b0;
    logic            rd_valid;
    logic [W_EL-1:0] rd_data;
    logic [AW:0]     count;
    logic            full;
    logic            almost_full;
    logic            sb_overflow;
    logic            sb_proto_err;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] ovf_cnt;

    int n_checks = 0;
    int n_errors = 0;

    sideband_commit_buffer #(
        .W_EL(W_EL), .ADDR_WIDTH(AW), .AFULL_MARGIN(4), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .sb_start(sb_start), .sb_wen(sb_wen), .sb_wdata(sb_wdata),
        .sb_commit(sb_commit), .sb_drop(sb_drop),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .count(count), .full(full), .almost_full(almost_full),
        .sb_overflow(sb_overflow), .sb_proto_err(sb_proto_err),
        .drop_cnt(drop_cnt), .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: frame state, staged value, a queue of committed descriptors.
    logic [W_EL-1:0] m_q[$];
    bit              m_open;
    logic [W_EL-1:0] m_stage;
    int              m_drop;
    int              m_ovf;
    bit              m_perr;
    bit              m_ovfp;

    task automatic model_reset();
        m_q.delete();
        m_open  = 1'b0;
        m_stage = '0;
        m_drop  = 0;
        m_ovf   = 0;
        m_perr  = 1'b0;
        m_ovfp  = 1'b0;
    endtask

    task automatic model_cycle(input bit st, input bit we, input logic [W_EL-1:0] wd,
                               input bit cm, input bit dr, input bit rr);
        bit              do_pop;
        bit              do_push;
        logic [W_EL-1:0] pdata;
        do_pop  = (m_q.size() != 0) && rr;
        do_push = 1'b0;
        pdata   = '0;
        m_perr  = 1'b0;
        m_ovfp  = 1'b0;
        if (!m_open) begin
            if (st) begin
                m_open  = 1'b1;
                m_stage = '0;
            end else if (we || cm || dr) begin
                m_perr = 1'b1;
            end
        end else if (dr) begin
            m_open = 1'b0;
            if (m_drop < CMAX) m_drop++;
        end else if (st) begin
            m_stage = '0;
            if (m_drop < CMAX) m_drop++;
        end else if (cm) begin
            m_open = 1'b0;
            pdata  = we ? wd : m_stage;
            if (m_q.size() < DEPTH || do_pop) begin
                do_push = 1'b1;
            end else begin
                m_ovfp = 1'b1;
                if (m_ovf < CMAX) m_ovf++;
            end
        end else if (we) begin
            m_stage = wd;
        end
        if (do_pop) void'(m_q.pop_front());
        if (do_push) m_q.push_back(pdata);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, take the edge, sample 1 time unit later.
    task automatic step(input bit st, input bit we, input logic [W_EL-1:0] wd,
                        input bit cm, input bit dr, input bit rr);
        sb_start  = st;
        sb_wen    = we;
        sb_wdata  = wd;
        sb_commit = cm;
        sb_drop   = dr;
        rd_ready  = rr;
        model_cycle(st, we, wd, cm, dr, rr);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        sb_start  = 1'b0;
        sb_wen    = 1'b0;
        sb_commit = 1'b0;
        sb_drop   = 1'b0;
        rd_ready  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic check_model(input string tag);
        check({tag, " rd_valid"}, 32'(rd_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check({tag, " rd_data"}, 32'(rd_data), 32'(m_q[0]));
        check({tag, " count"}, 32'(count), 32'(m_q.size()));
        check({tag, " full"}, 32'(full), 32'(m_q.size() == DEPTH));
        check({tag, " almost_full"}, 32'(almost_full), 32'(m_q.size() >= DEPTH - 4));
        check({tag, " sb_overflow"}, 32'(sb_overflow), 32'(m_ovfp));
        check({tag, " sb_proto_err"}, 32'(sb_proto_err), 32'(m_perr));
        check({tag, " drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
        check({tag, " ovf_cnt"}, 32'(ovf_cnt), 32'(m_ovf));
    endtask

    typedef struct {
        logic            st;
        logic            we;
        logic [W_EL-1:0] wd;
        logic            cm;
        logic            dr;
        logic            rr;
        logic            exp_valid;
        logic [W_EL-1:0] exp_data;
        int              exp_count;
        logic            exp_perr;
        int              exp_drop;
    } vec_t;

    vec_t vecs[16];

    initial begin
        // st we wd cm dr rr | valid data count perr drop
        vecs[0]  = '{1, 0, 'h0,  0, 0, 0, 0, 'h0,  0, 0, 0};
        vecs[1]  = '{0, 1, 'hA5, 0, 0, 0, 0, 'h0,  0, 0, 0};
        vecs[2]  = '{0, 0, 'h0,  1, 0, 0, 1, 'hA5, 1, 0, 0};
        vecs[3]  = '{0, 0, 'h0,  0, 0, 1, 0, 'h0,  0, 0, 0};
        vecs[4]  = '{1, 0, 'h0,  0, 0, 0, 0, 'h0,  0, 0, 0};
        vecs[5]  = '{0, 1, 'h11, 0, 0, 0, 0, 'h0,  0, 0, 0};
        vecs[6]  = '{0, 0, 'h0,  0, 1, 0, 0, 'h0,  0, 0, 1};
        vecs[7]  = '{0, 0, 'h0,  1, 0, 0, 0, 'h0,  0, 1, 1};
        vecs[8]  = '{0, 0, 'h0,  0, 0, 0, 0, 'h0,  0, 0, 1};
        vecs[9]  = '{0, 1, 'h22, 0, 0, 0, 0, 'h0,  0, 1, 1};
        vecs[10] = '{1, 0, 'h0,  0, 0, 0, 0, 'h0,  0, 0, 1};
        vecs[11] = '{0, 1, 'h3,  0, 0, 0, 0, 'h0,  0, 0, 1};
        vecs[12] = '{1, 0, 'h0,  0, 0, 0, 0, 'h0,  0, 0, 2};
        vecs[13] = '{0, 1, 'h4,  0, 0, 0, 0, 'h0,  0, 0, 2};
        vecs[14] = '{0, 0, 'h0,  1, 0, 0, 1, 'h4,  1, 0, 2};
        vecs[15] = '{0, 0, 'h0,  0, 0, 0, 1, 'h4,  1, 0, 2};

        model_reset();
        do_reset();
        check("reset rd_valid", 32'(rd_valid), 32'd0);
        check("reset count", 32'(count), 32'd0);
        check("reset full", 32'(full), 32'd0);
        check("reset almost_full", 32'(almost_full), 32'd0);
        check("reset sb_overflow", 32'(sb_overflow), 32'd0);
        check("reset sb_proto_err", 32'(sb_proto_err), 32'd0);
        check("reset drop_cnt", 32'(drop_cnt), 32'd0);
        check("reset ovf_cnt", 32'(ovf_cnt), 32'd0);

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].st, vecs[i].we, vecs[i].wd, vecs[i].cm, vecs[i].dr, vecs[i].rr);
            check($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) check($sformatf("vec%0d rd_data", i), 32'(rd_data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d sb_proto_err", i), 32'(sb_proto_err), 32'(vecs[i].exp_perr));
            check($sformatf("vec%0d drop_cnt", i), 32'(drop_cnt), 32'(vecs[i].exp_drop));
        end

        // Reset while a frame is open discards everything without counting.
        step(1, 0, 'h0, 0, 0, 0);
        step(0, 1, 'h7, 0, 0, 0);
        do_reset();
        check("midopen reset count", 32'(count), 32'd0);
        check("midopen reset rd_valid", 32'(rd_valid), 32'd0);
        check("midopen reset drop_cnt", 32'(drop_cnt), 32'd0);
        step(0, 0, 'h0, 1, 0, 0);
        check("post reset commit proto_err", 32'(sb_proto_err), 32'd1);
        check("post reset commit count", 32'(count), 32'd0);

        // Fill to DEPTH with values 0..DEPTH-1 (write bypassed on the commit cycle).
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 0, 'h0, 0, 0, 0);
            step(0, 1, W_EL'(i), 1, 0, 0);
            check($sformatf("fill%0d count", i), 32'(count), 32'(i + 1));
            check($sformatf("fill%0d almost_full", i), 32'(almost_full), 32'((i + 1) >= DEPTH - 4));
            check($sformatf("fill%0d full", i), 32'(full), 32'((i + 1) == DEPTH));
        end
        check("fill head", 32'(rd_data), 32'd0);

        step(1, 0, 'h0, 0, 0, 0);
        step(0, 1, 'h2AA, 1, 0, 0);
        check("overflow pulse", 32'(sb_overflow), 32'd1);
        check("overflow ovf_cnt", 32'(ovf_cnt), 32'd1);
        check("overflow head", 32'(rd_data), 32'd0);
        check("overflow count", 32'(count), 32'(DEPTH));
        step(0, 0, 'h0, 0, 0, 0);
        check("overflow pulse clears", 32'(sb_overflow), 32'd0);

        // Commit into a full FIFO while the head pops in the same cycle.
        step(1, 0, 'h0, 0, 0, 0);
        step(0, 1, 'h1FF, 1, 0, 1);
        check("full swap overflow", 32'(sb_overflow), 32'd0);
        check("full swap count", 32'(count), 32'(DEPTH));
        check("full swap full", 32'(full), 32'd1);
        check("full swap ovf_cnt", 32'(ovf_cnt), 32'd1);
        for (int i = 1; i < DEPTH; i++) begin
            check($sformatf("drain%0d rd_data", i), 32'(rd_data), 32'(i));
            step(0, 0, 'h0, 0, 0, 1);
        end
        check("drain last rd_valid", 32'(rd_valid), 32'd1);
        check("drain last rd_data", 32'(rd_data), 32'h1FF);
        step(0, 0, 'h0, 0, 0, 1);
        check("drain empty rd_valid", 32'(rd_valid), 32'd0);
        check("drain empty count", 32'(count), 32'd0);
        check("drain empty almost_full", 32'(almost_full), 32'd0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(7) == 0), ($urandom_range(2) == 0), W_EL'($urandom),
                 ($urandom_range(4) == 0), ($urandom_range(11) == 0), ($urandom_range(1) == 0));
            check_model($sformatf("rand%0d", i));
        end

        // Drop counter saturation: back-to-back starts abort one frame per cycle.
        do_reset();
        step(1, 0, 'h0, 0, 0, 0);
        for (int i = 1; i <= CMAX + 2; i++) begin
            step(1, 0, 'h0, 0, 0, 0);
            if (i == CMAX - 1) check("sat below max", 32'(drop_cnt), 32'(CMAX - 1));
        end
        check("sat at max", 32'(drop_cnt), 32'(CMAX));
        step(0, 0, 'h0, 0, 1, 0);
        check("sat hold after drop", 32'(drop_cnt), 32'(CMAX));
        check("sat count", 32'(count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
